// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Counter state is held at DIV_MAX_W bits, so WIDTH must not exceed 32.
package clk_div_pkg;

  localparam int MAX_CH    = 16;
  localparam int DIV_MAX_W = 32;

  typedef logic [DIV_MAX_W-1:0] div_t;

  typedef struct packed {
    div_t cnt;
    logic lvl;
    logic pending;
  } chan_state_t;

  function automatic int ch_width(input int num_ch);
    int n;
    n = (num_ch > MAX_CH) ? MAX_CH : num_ch;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_chan_clk_div_if.sv
// Divisor configuration port (valid/ready) of multi_chan_clk_div.
// cfg_hi exists only when CLK_DIV_DUTY_EN is defined.
interface multi_chan_clk_div_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 28
);

  localparam int CH_W = clk_div_pkg::ch_width(NUM_CH);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [WIDTH-1:0]  cfg_div;
`ifdef CLK_DIV_DUTY_EN
  logic [WIDTH-1:0]  cfg_hi;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_hi, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_hi, output cfg_ready);
`else
  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
`endif

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, output level, shadow/active divisors, pending apply.
// CLK_DIV_DUTY_EN adds a separate high-half divisor.
module clk_div_chan #(
  parameter int               WIDTH       = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(28'h17D7840)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_lo,
`ifdef CLK_DIV_DUTY_EN
  input  logic [WIDTH-1:0] i_hi,
`endif
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pending
);

  import clk_div_pkg::*;

  chan_state_t      r_state;
  logic             r_tick;
  logic [WIDTH-1:0] r_act_lo;
  logic [WIDTH-1:0] r_sh_lo;
`ifdef CLK_DIV_DUTY_EN
  logic [WIDTH-1:0] r_act_hi;
  logic [WIDTH-1:0] r_sh_hi;
`endif

  logic [WIDTH-1:0] w_d;
  logic             w_idle;
  logic             w_term;
  logic             w_apply;

`ifdef CLK_DIV_DUTY_EN
  assign w_d = r_state.lvl ? r_act_hi : r_act_lo;
`else
  assign w_d = r_act_lo;
`endif

  assign w_idle  = !i_en || (w_d == '0);
  assign w_term  = !w_idle && (r_state.cnt == (div_t'(w_d) - div_t'(1)));
  // Shadow is only promoted at a half boundary (or when nothing is counting), so no runt half.
  assign w_apply = r_state.pending && (i_sync || w_term || w_idle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= '0;
      r_tick   <= 1'b0;
      r_act_lo <= DEFAULT_DIV;
      r_sh_lo  <= DEFAULT_DIV;
`ifdef CLK_DIV_DUTY_EN
      r_act_hi <= DEFAULT_DIV;
      r_sh_hi  <= DEFAULT_DIV;
`endif
    end else begin
      if (i_sync) begin
        r_state.cnt <= '0;
        r_state.lvl <= 1'b0;
        r_tick      <= 1'b0;
      end else if (w_idle) begin
        r_tick      <= 1'b0;
      end else if (w_term) begin
        r_state.cnt <= '0;
        r_state.lvl <= ~r_state.lvl;
        r_tick      <= 1'b1;
      end else begin
        r_state.cnt <= r_state.cnt + div_t'(1);
        r_tick      <= 1'b0;
      end

      if (w_apply) begin
        r_act_lo <= r_sh_lo;
`ifdef CLK_DIV_DUTY_EN
        r_act_hi <= r_sh_hi;
`endif
      end

      // A write is only accepted while nothing is pending, so it never races an apply.
      if (i_wr) begin
        r_sh_lo         <= i_lo;
`ifdef CLK_DIV_DUTY_EN
        r_sh_hi         <= i_hi;
`endif
        r_state.pending <= 1'b1;
      end else if (w_apply) begin
        r_state.pending <= 1'b0;
      end
    end
  end

  assign o_clk     = r_state.lvl;
  assign o_tick    = r_tick;
  assign o_pending = r_state.pending;

endmodule

// File: rtl/multi_chan_clk_div.sv
// N-channel programmable clock divider / blink generator with run-time reprogramming.
// Define CLK_DIV_DUTY_EN for independent high/low half counts per channel.
module multi_chan_clk_div #(
  parameter int               NUM_CH      = 4,
  parameter int               WIDTH       = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(28'h17D7840)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   en,
  input  logic                sync,
  multi_chan_clk_div_if.slave cfg,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick,
  output logic                busy
);

  import clk_div_pkg::*;

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_wr;
  logic              w_ready;

  // Out-of-range channel numbers match nothing, so they stay ready and are silently dropped.
  always_comb begin
    w_ready = 1'b1;
    w_wr    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        w_ready = !w_pending[i];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_valid && w_ready && (cfg.cfg_ch == CH_W'(i))) begin
        w_wr[i] = 1'b1;
      end
    end
  end

  assign cfg.cfg_ready = w_ready;
  assign busy          = |w_pending;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_en      (en[g]),
      .i_sync    (sync),
      .i_wr      (w_wr[g]),
      .i_lo      (cfg.cfg_div),
`ifdef CLK_DIV_DUTY_EN
      .i_hi      (cfg.cfg_hi),
`endif
      .o_clk     (clk_out[g]),
      .o_tick    (tick[g]),
      .o_pending (w_pending[g])
    );
  end

endmodule
